// File: rtl/prio_enc_pkg.sv
// Shared constants, FSM state type and index decode for the 8-to-3
// handshaked priority encoder.
package prio_enc_pkg;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Same mapping as decoder_3x8: index -> one-hot vector.
  function automatic logic [N_IN-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_IN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational 8-to-3 fixed-priority encoder; HIGH_WINS selects which end
// of the vector has priority.
module prio_enc_8x3
  import prio_enc_pkg::*;
#(
  parameter int unsigned HIGH_WINS = 1
) (
  input  logic [N_IN-1:0]  in,
  output logic [IDX_W-1:0] out,
  output logic             any
);

  // Scan towards the priority end so the last hit is the winner.
  always_comb begin
    out = '0;
    any = |in;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (HIGH_WINS != 0) begin
        if (in[i]) out = IDX_W'(i);
      end else begin
        if (in[N_IN-1-i]) out = IDX_W'(N_IN-1-i);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_8x3_hs.sv
// Sticky request capture, fixed-priority selection and valid/ready delivery
// of a 3-bit index, with a saturating count of requests lost to pending bits.
module prio_encoder_8x3_hs
  import prio_enc_pkg::*;
#(
  parameter int unsigned HIGH_WINS = 1,
  parameter int unsigned DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_IN-1:0]   req,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_IN-1:0]   pending,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx_next;
  logic [N_IN-1:0]    req_new, clr, pending_next;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic               acc;
  logic [3:0]         drops;
  logic [DROP_W:0]    drop_sum;
  logic [DROP_W-1:0]  drop_next;

  prio_enc_8x3 #(.HIGH_WINS(HIGH_WINS)) u_enc (
    .in  (pending),
    .out (sel_idx),
    .any (sel_any)
  );

  assign out_valid    = (state == HOLD);
  assign acc          = out_valid && out_ready;
  assign req_new      = en ? req : '0;
  assign clr          = acc ? onehot(out_idx) : '0;
  assign pending_next = (pending & ~clr) | req_new;

  // A clear and a fresh set of the same bit is a new event, not a drop.
  always_comb begin
    drops = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (req_new[i] && pending[i] && !clr[i]) drops = drops + 4'd1;
    end
    drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(drops);
    drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_comb begin
    state_next = state;
    idx_next   = out_idx;
    unique case (state)
      IDLE: begin
        if (en && sel_any) begin
          idx_next   = sel_idx;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_idx  <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      out_idx  <= idx_next;
      pending  <= pending_next;
      drop_cnt <= drop_next;
    end
  end

endmodule
